// File: rtl/bounded_count_array.sv
`default_nettype none
// ============================================================================
// bounded_count_array : per-channel bounded up-counters with programmable
//                       limit/guard, wrap or saturate, sticky guard violation.
// Revision 1.0
// ============================================================================
module bounded_count_array #(
   parameter int N_CH      = 4,
   parameter int W         = 15,
   parameter int LIMIT_RST = 399,
   parameter int GUARD_RST = 500,
   parameter int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   sel,
   input  logic [N_CH-1:0]   mode_wrap,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CW-1:0]     cfg_ch,
   input  logic [W-1:0]      cfg_limit,
   input  logic [W-1:0]      cfg_guard,
   output logic [N_CH*W-1:0] count,
   output logic [N_CH-1:0]   done,
   output logic [N_CH-1:0]   wrap_pulse,
   output logic [N_CH-1:0]   viol
);

   localparam logic [W-1:0] c_limit_rst = W'(LIMIT_RST);
   localparam logic [W-1:0] c_guard_rst = W'(GUARD_RST);

   logic cfg_ready_q;
   logic cfg_ready_d;
   logic w_cfg_fire;

   // One dead cycle after every accepted write caps the config rate at 1/2.
   always_comb begin
      w_cfg_fire  = cfg_valid && cfg_ready_q;
      cfg_ready_d = !w_cfg_fire;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_ready_q <= 1'b1;
      end else begin
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready = cfg_ready_q;

   generate
      for (genvar c = 0; c < N_CH; c++) begin : g_ch
         localparam logic [CW-1:0] c_idx = CW'(c);

         logic [W-1:0] count_q, count_d;
         logic [W-1:0] limit_q, limit_d;
         logic [W-1:0] guard_q, guard_d;
         logic         done_q, done_d;
         logic         wrap_q, wrap_d;
         logic         viol_q, viol_d;
         logic         w_hit;

         always_comb begin
            w_hit   = w_cfg_fire && (cfg_ch == c_idx);
            count_d = count_q;
            limit_d = limit_q;
            guard_d = guard_q;
            wrap_d  = 1'b0;
            viol_d  = viol_q;
            if (w_hit) begin
               count_d = '0;
               limit_d = cfg_limit;
               guard_d = cfg_guard;
               viol_d  = 1'b0;
            end else begin
               if ((count_q < limit_q) && (count_q >= guard_q)) begin
                  viol_d = 1'b1;
               end
               if (sel[c]) begin
                  if (count_q < limit_q) begin
                     count_d = count_q + W'(1);
                  end else if ((count_q == limit_q) && mode_wrap[c]) begin
                     count_d = '0;
                     wrap_d  = 1'b1;
                  end
               end
            end
            done_d = (count_d == limit_d) && !mode_wrap[c];
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               count_q <= '0;
               limit_q <= c_limit_rst;
               guard_q <= c_guard_rst;
               done_q  <= 1'b0;
               wrap_q  <= 1'b0;
               viol_q  <= 1'b0;
            end else begin
               count_q <= count_d;
               limit_q <= limit_d;
               guard_q <= guard_d;
               done_q  <= done_d;
               wrap_q  <= wrap_d;
               viol_q  <= viol_d;
            end
         end

         assign count[c*W +: W] = count_q;
         assign done[c]         = done_q;
         assign wrap_pulse[c]   = wrap_q;
         assign viol[c]         = viol_q;
      end
   endgenerate

endmodule
`default_nettype wire
